// File: rtl/div_sequencer_if.sv
// div_sequencer_if: operand, divider and result handshake bundle for div_sequencer.
interface div_sequencer_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_x;
   logic [WIDTH-1:0] in_y;
   logic             div_reset;
   logic [WIDTH-1:0] div_x;
   logic [WIDTH-1:0] div_y;
   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] div_r;
   logic             div_done;
   logic             div_error;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_r;
   logic             out_error;
   logic             out_timeout;
   modport slave (
      input  in_valid, in_x, in_y, div_q, div_r, div_done, div_error, out_ready,
      output in_ready, div_reset, div_x, div_y, out_valid, out_q, out_r, out_error, out_timeout
   );
   modport master (
      output in_valid, in_x, in_y, div_q, div_r, div_done, div_error, out_ready,
      input  in_ready, div_reset, div_x, div_y, out_valid, out_q, out_r, out_error, out_timeout
   );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: runs one restoring division per accepted operand pair, with a watchdog on div_done.
module div_sequencer #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 15
) (
   input logic           clock,
   input logic           reset,
   div_sequencer_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;
   state_t        state, next_state;
   logic [CW-1:0] cnt;
   logic          accept, finish, expire;
   assign bus.in_ready  = (state == IDLE) | ((state == OUT) & bus.out_ready);
   assign bus.div_reset = reset | (state == LOAD);
   assign bus.out_valid = (state == OUT);
   assign accept = bus.in_valid & bus.in_ready;
   // done is only trusted in RUN; during LOAD it may still reflect the previous division
   assign finish = (state == RUN) & bus.div_done;
   assign expire = (state == RUN) & ~bus.div_done & (cnt == CW'(TIMEOUT - 1));
   always_comb begin
      next_state = state;
      case (state)
         IDLE: next_state = accept ? LOAD : IDLE;
         LOAD: next_state = RUN;
         RUN:  next_state = (finish | expire) ? OUT : RUN;
         OUT:  next_state = accept ? LOAD : bus.out_ready ? IDLE : OUT;
         default: next_state = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         bus.div_x       <= '0;
         bus.div_y       <= '0;
         bus.out_q       <= '0;
         bus.out_r       <= '0;
         bus.out_error   <= 1'b0;
         bus.out_timeout <= 1'b0;
      end else begin
         state <= next_state;
         cnt   <= (state == LOAD) ? '0 : (state == RUN) ? cnt + 1'b1 : cnt;
         if (accept) begin
            bus.div_x <= bus.in_x;
            bus.div_y <= bus.in_y;
         end
         if (finish) begin
            bus.out_q       <= bus.div_error ? '1 : bus.div_q;
            bus.out_r       <= bus.div_error ? bus.div_x : bus.div_r;
            bus.out_error   <= bus.div_error;
            bus.out_timeout <= 1'b0;
         end else if (expire) begin
            bus.out_q       <= '0;
            bus.out_r       <= '0;
            bus.out_error   <= 1'b1;
            bus.out_timeout <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed scoreboard bench with a behavioural 8-bit restoring divider.
module tb_div_sequencer;
   logic clock = 0;
   logic reset = 1;
   logic hang  = 0;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;
   div_sequencer_if #(.WIDTH(8)) bus ();
   div_sequencer #(.WIDTH(8), .TIMEOUT(15)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   // divider model: 8 steps after reset for nonzero y, zero flagged after a single step
   int       dcnt = 0;
   logic [7:0] mq = 0, mr = 0;
   logic       merr = 0;
   always @(posedge clock) begin
      if (bus.div_reset) begin
         dcnt <= (bus.div_y == 0) ? 1 : 8;
         mq   <= (bus.div_y == 0) ? 8'hAA : bus.div_x / bus.div_y;
         mr   <= (bus.div_y == 0) ? 8'h55 : bus.div_x % bus.div_y;
         merr <= (bus.div_y == 0);
      end else if (dcnt != 0) dcnt <= dcnt - 1;
   end
   assign bus.div_done  = ~hang & (dcnt == 0);
   assign bus.div_q     = mq;
   assign bus.div_r     = mr;
   assign bus.div_error = merr;
   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       e;
      logic       t;
      int         when;
   } exp_t;
   exp_t sb[$];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask
   // monitor: first appearance of a result checks latency, handshake checks payload
   logic shown = 0;
   always @(negedge clock) begin
      if (reset) shown <= 0;
      else if (bus.out_valid) begin
         if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
         else begin
            if (!shown) chk("latency", cyc, sb[0].when);
            if (bus.out_ready) begin
               chk("out_q", bus.out_q, sb[0].q);
               chk("out_r", bus.out_r, sb[0].r);
               chk("out_error", bus.out_error, sb[0].e);
               chk("out_timeout", bus.out_timeout, sb[0].t);
               void'(sb.pop_front());
            end
         end
         shown <= ~bus.out_ready;
      end
   end
   task automatic send(input logic [7:0] x, y, input logic push, input logic [7:0] q, r,
                       input logic e, t, input int lat);
      int n = 0;
      @(negedge clock);
      bus.in_valid = 1;
      bus.in_x = x;
      bus.in_y = y;
      while (!bus.in_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!bus.in_ready) chk("accept_timeout", 0, 1);
      @(posedge clock);
      #1;
      if (push) sb.push_back('{q, r, e, t, cyc + lat});
      @(negedge clock);
      chk("div_reset_pulse", bus.div_reset, 1);
      chk("in_ready_load", bus.in_ready, 0);
      bus.in_valid = 0;
   endtask
   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk("drain_timeout", sb.size(), 0);
   endtask
   initial begin
      int n;
      bus.in_valid = 0;
      bus.in_x = 0;
      bus.in_y = 0;
      bus.out_ready = 1;
      repeat (2) @(negedge clock);
      chk("rst_div_reset", bus.div_reset, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_q", bus.out_q, 0);
      chk("rst_out_error", bus.out_error, 0);
      chk("rst_div_x", bus.div_x, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      reset = 0;
      // basic and divide-by-zero
      send(100, 7, 1, 14, 2, 0, 0, 10);
      drain();
      send(55, 0, 1, 8'hFF, 55, 1, 0, 3);
      drain();
      // backpressure
      bus.out_ready = 0;
      send(255, 16, 1, 15, 15, 0, 0, 10);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clock);
         n++;
      end
      repeat (20) begin
         @(negedge clock);
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_out_q", bus.out_q, 15);
         chk("bp_in_ready", bus.in_ready, 0);
      end
      @(posedge clock);
      #1 bus.out_ready = 1;
      drain();
      @(negedge clock);
      chk("bp_idle_out_valid", bus.out_valid, 0);
      chk("bp_idle_in_ready", bus.in_ready, 1);
      chk("bp_hold_q", bus.out_q, 15);
      // back-to-back
      send(200, 9, 1, 22, 2, 0, 0, 10);
      send(9, 200, 1, 0, 9, 0, 0, 10);
      drain();
      // watchdog
      hang = 1;
      send(10, 3, 1, 0, 0, 1, 1, 16);
      drain();
      hang = 0;
      // reset mid-RUN discards the pending op
      send(100, 7, 0, 0, 0, 0, 0, 0);
      repeat (4) @(negedge clock);
      reset = 1;
      @(negedge clock);
      chk("midrst_div_reset", bus.div_reset, 1);
      reset = 0;
      @(negedge clock);
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_in_ready", bus.in_ready, 1);
      send(50, 5, 1, 10, 0, 0, 0, 10);
      drain();
      repeat (3) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
